// File: rtl/seq_feeder_pkg.sv
// Shared types and constants for the cypher detector's sequence feeder.
package seq_feeder_pkg;

  localparam int DIGIT_W = 4;
  localparam int CNT_W = 8;
  localparam logic [DIGIT_W-1:0] PAD_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_fifo.sv
// Circular digit buffer with occupancy tracking and a sticky drop flag.
module seq_fifo
  import seq_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push_i,
  input  logic [DIGIT_W-1:0] push_data_i,
  input  logic               pop_i,
  output logic [DIGIT_W-1:0] head_o,
  output logic [AW:0]        level_o,
  output logic               full_o,
  output logic               empty_o,
  output logic               overflow_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DIGIT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wrPtr_q, wrPtr_d;
  logic [AW-1:0]      rdPtr_q, rdPtr_d;
  logic [AW:0]        count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               accept;
  logic               doPop;

  // Acceptance looks only at the occupancy at the start of the cycle, so a
  // push into a full buffer is dropped even when a pop frees a slot.
  assign accept = push_i && (count_q < DEPTH_C);
  assign doPop  = pop_i && (count_q != '0);

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (accept) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop) rdPtr_d = rdPtr_q + 1'b1;
    if (accept && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (!accept && doPop) begin
      count_d = count_q - 1'b1;
    end
    if (push_i && !accept) overflow_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clock) begin
    if (accept) mem_q[wrPtr_q] <= push_data_i;
  end

  assign head_o     = mem_q[rdPtr_q];
  assign level_o    = count_q;
  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);
  assign overflow_o = overflow_q;

endmodule

// File: rtl/seq_feeder.sv
// Buffers keypad digits and streams them one per clock into the cypher detector.
// Optional SEQ_FEEDER_CNT_EN adds a saturating per-stream digit counter output.
module seq_feeder
  import seq_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter logic [DIGIT_W-1:0] PAD = PAD_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [DIGIT_W-1:0] push_data,
  input  logic               start,
  input  logic               hold,
  output logic [DIGIT_W-1:0] seq_out,
  output logic               seq_valid,
  output logic               busy,
  output logic               done,
  output logic               full,
  output logic               empty,
  output logic [AW:0]        level,
  output logic               overflow
`ifdef SEQ_FEEDER_CNT_EN
  ,
  output logic [CNT_W-1:0]   stream_cnt
`endif
);

  state_e             state_q;
  logic [DIGIT_W-1:0] seqOut_q;
  logic               seqValid_q;
  logic               done_q;
  logic [DIGIT_W-1:0] head;
  logic               pop;
`ifdef SEQ_FEEDER_CNT_EN
  logic [CNT_W-1:0]   streamCnt_q;
`endif

  assign pop = (state_q == ST_STREAM) && !hold && !empty;

  seq_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .head_o     (head),
    .level_o    (level),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

  // An empty buffer seen in STREAM means the previous cycle presented the last
  // digit, which places the done pulse one cycle after the final valid digit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      seqOut_q   <= PAD;
      seqValid_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef SEQ_FEEDER_CNT_EN
      streamCnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          seqOut_q   <= PAD;
          seqValid_q <= 1'b0;
          done_q     <= 1'b0;
          if (start) begin
`ifdef SEQ_FEEDER_CNT_EN
            streamCnt_q <= '0;
`endif
            if (empty) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (empty) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            seqValid_q <= 1'b0;
            seqOut_q   <= PAD;
          end else if (hold) begin
            seqValid_q <= 1'b0;
          end else begin
            seqOut_q   <= head;
            seqValid_q <= 1'b1;
`ifdef SEQ_FEEDER_CNT_EN
            if (streamCnt_q != '1) streamCnt_q <= streamCnt_q + 1'b1;
`endif
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          done_q     <= 1'b0;
          seqValid_q <= 1'b0;
          seqOut_q   <= PAD;
        end
        default: begin
          state_q    <= ST_IDLE;
          done_q     <= 1'b0;
          seqValid_q <= 1'b0;
          seqOut_q   <= PAD;
        end
      endcase
    end
  end

  assign seq_out   = seqOut_q;
  assign seq_valid = seqValid_q;
  assign done      = done_q;
  assign busy      = (state_q == ST_STREAM);
`ifdef SEQ_FEEDER_CNT_EN
  assign stream_cnt = streamCnt_q;
`endif

endmodule

// File: tb/tb_seq_feeder.sv
// Randomized and directed bench for seq_feeder against a queue-based reference model.
module tb_seq_feeder;
  import seq_feeder_pkg::*;

  logic       clock;
  logic       reset;
  logic       push;
  logic [3:0] pushData;
  logic       start;
  logic       hold;
  logic [3:0] seqOut;
  logic       seqValid;
  logic       busy;
  logic       done;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
`ifdef SEQ_FEEDER_CNT_EN
  logic [7:0] streamCnt;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: a plain queue of buffered digits plus run/finish flags.
  logic [3:0] mq[$];
  bit         mRunning;
  bit         mFinish;
  bit         mOverflow;
  logic [3:0] expOut;
  bit         expValid;
  bit         expDone;
  int         mCnt;

  logic [3:0] captured[$];
  int         doneCount;

  seq_feeder dut (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(pushData),
    .start    (start),
    .hold     (hold),
    .seq_out  (seqOut),
    .seq_valid(seqValid),
    .busy     (busy),
    .done     (done),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
`ifdef SEQ_FEEDER_CNT_EN
    ,
    .stream_cnt(streamCnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelUpdate(input logic r, input logic p, input logic [3:0] d, input logic s, input logic h);
    int n;
    n = mq.size();
    if (!r) begin
      mq.delete();
      mRunning = 0; mFinish = 0; mOverflow = 0;
      expOut = PAD_DEFAULT; expValid = 0; expDone = 0; mCnt = 0;
      return;
    end
    expValid = 0;
    expDone = 0;
    if (mFinish) begin
      mFinish = 0;
      expOut = PAD_DEFAULT;
    end else if (mRunning) begin
      if (n == 0) begin
        mRunning = 0; mFinish = 1; expDone = 1; expOut = PAD_DEFAULT;
      end else if (!h) begin
        expOut = mq.pop_front();
        expValid = 1;
        if (mCnt < 255) mCnt++;
      end
    end else begin
      expOut = PAD_DEFAULT;
      if (s) begin
        mCnt = 0;
        if (n > 0) mRunning = 1;
        else begin
          mFinish = 1; expDone = 1;
        end
      end
    end
    if (p) begin
      if (n < 16) mq.push_back(d);
      else mOverflow = 1;
    end
  endtask

  task automatic compareAll();
    checkOutput("seq_valid", 32'(seqValid), 32'(expValid));
    checkOutput("seq_out", 32'(seqOut), 32'(expOut));
    checkOutput("done", 32'(done), 32'(expDone));
    checkOutput("busy", 32'(busy), 32'(mRunning));
    checkOutput("level", 32'(level), 32'(mq.size()));
    checkOutput("full", 32'(full), 32'(mq.size() == 16));
    checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
    checkOutput("overflow", 32'(overflow), 32'(mOverflow));
`ifdef SEQ_FEEDER_CNT_EN
    checkOutput("stream_cnt", 32'(streamCnt), 32'(mCnt));
`endif
    if (seqValid === 1'b1) captured.push_back(seqOut);
    if (done === 1'b1) doneCount++;
  endtask

  // Inputs change just after a falling edge; outputs are checked at the next falling edge.
  task automatic applyStimulus(input logic r, input logic p, input logic [3:0] d, input logic s, input logic h);
    reset = r; push = p; pushData = d; start = s; hold = h;
    @(posedge clock);
    modelUpdate(r, p, d, s, h);
    @(negedge clock);
    compareAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic pushDigit(input logic [3:0] d);
    applyStimulus(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    captured.delete();
    doneCount = 0;
  endtask

  task automatic checkRun(input string tag, input int first, input int n);
    checkOutput({tag, " digits"}, 32'(captured.size()), 32'(n));
    for (int i = 0; i < n && i < captured.size(); i++)
      checkOutput({tag, " digit"}, 32'(captured[i]), 32'((first + i) % 16));
  endtask

  initial begin
    int vExp[5];
    int oExp[5];
    int hSeq[5];
    int pushed;
    int guard;
    reset = 1'b0; push = 1'b0; pushData = 4'h0; start = 1'b0; hold = 1'b0;
    @(negedge clock);

    // Reset state
    doReset();
    checkOutput("rst seq_out", 32'(seqOut), 32'hF);
    checkOutput("rst empty", 32'(empty), 32'd1);
    checkOutput("rst level", 32'(level), 32'd0);

    // Basic stream of 1..4 with exact latency
    for (int i = 1; i <= 4; i++) pushDigit(4'(i));
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("s1 valid at start+1", 32'(seqValid), 32'd0);
    checkOutput("s1 busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      checkOutput("s1 valid", 32'(seqValid), 32'd1);
      checkOutput("s1 out", 32'(seqOut), 32'(i));
    end
    idle(1);
    checkOutput("s1 done", 32'(done), 32'd1);
    checkOutput("s1 pad", 32'(seqOut), 32'hF);
    idle(2);
    checkRun("s1", 1, 4);
    checkOutput("s1 done count", 32'(doneCount), 32'd1);

    // Overflow: 16 digits then a dropped 5
    doReset();
    for (int i = 0; i < 16; i++) pushDigit(4'(i));
    pushDigit(4'h5);
    checkOutput("s2 full", 32'(full), 32'd1);
    checkOutput("s2 level", 32'(level), 32'd16);
    checkOutput("s2 overflow", 32'(overflow), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(20);
    checkRun("s2", 0, 16);
    checkOutput("s2 overflow sticky", 32'(overflow), 32'd1);

    // Hold for two cycles after the first digit
    doReset();
    for (int i = 1; i <= 3; i++) pushDigit(4'(i));
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    vExp = '{1, 0, 0, 1, 1};
    oExp = '{1, 1, 1, 2, 3};
    hSeq = '{0, 1, 1, 0, 0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, hSeq[i] != 0);
      checkOutput("s3 valid", 32'(seqValid), 32'(vExp[i]));
      checkOutput("s3 out", 32'(seqOut), 32'(oExp[i]));
    end
    idle(3);
    checkRun("s3", 1, 3);

    // Start with an empty buffer
    doReset();
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("s4 done", 32'(done), 32'd1);
    checkOutput("s4 busy", 32'(busy), 32'd0);
    idle(2);
    checkOutput("s4 done cleared", 32'(done), 32'd0);
    checkOutput("s4 no digits", 32'(captured.size()), 32'd0);

    // Append during a stream
    doReset();
    pushDigit(4'h7);
    pushDigit(4'h8);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    idle(6);
    checkRun("s5", 7, 3);
    checkOutput("s5 done count", 32'(doneCount), 32'd1);
    checkOutput("s5 level", 32'(level), 32'd0);

    // Reset mid-stream
    doReset();
    for (int i = 1; i <= 4; i++) pushDigit(4'(i));
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("s6 valid", 32'(seqValid), 32'd0);
    checkOutput("s6 out", 32'(seqOut), 32'hF);
    checkOutput("s6 level", 32'(level), 32'd0);
    checkOutput("s6 busy", 32'(busy), 32'd0);
    idle(3);
    checkOutput("s6 no done", 32'(doneCount), 32'd0);

`ifdef SEQ_FEEDER_CNT_EN
    // 300-digit run with continuous refill saturates the counter
    doReset();
    pushed = 0;
    for (int i = 0; i < 16; i++) begin
      pushDigit(4'(pushed));
      pushed++;
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    guard = 0;
    while (doneCount == 0 && guard < 2000) begin
      if (pushed < 300 && mq.size() < 16) begin
        applyStimulus(1'b1, 1'b1, 4'(pushed), 1'b0, 1'b0);
        pushed++;
      end else begin
        idle(1);
      end
      guard++;
    end
    checkOutput("cnt run finished", 32'(doneCount), 32'd1);
    idle(3);
    checkOutput("cnt saturated", 32'(streamCnt), 32'd255);
    checkRun("cnt", 0, 300);
`endif

    // Random traffic against the model
    doReset();
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 199) != 0,
                    $urandom_range(0, 1) == 1,
                    4'($urandom_range(0, 15)),
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seq_feeder.md
Name: seq_feeder

Overview:
- Upstream stage of the cypher detector.
- Buffers 4-bit digits pushed by a producer (keypad/host) in a circular FIFO.
- On command, streams the buffered digits one per clock onto the detector's 4-bit sequence input, with hold (back-pressure) and completion signalling.
- Drives a fixed pad digit whenever it is not streaming, so the detector never sees stale data.

Parameters:
- DEPTH, 16, FIFO entries (power of two, 2..256).
- AW, 4, pointer width = log2(DEPTH).
- PAD, 4'hF, digit driven on seq_out when no valid digit is presented.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising clock edge.
- push  in  1  write push_data into FIFO this cycle.
- push_data  in  4  digit to buffer.
- start  in  1  begin streaming buffered contents (sampled in IDLE only).
- hold  in  1  consumer stall; no pop and no valid while high.
- seq_out  out  4  digit to detector sequence input (registered).
- seq_valid  out  1  seq_out carries a new digit this cycle.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse when a stream finishes.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- level  out  AW+1  current occupancy.
- overflow  out  1  sticky, set on a dropped push.

Behaviour:
- Reset (reset=0 at edge) clears everything:
  - Pointers, count and overflow to 0.
  - State to IDLE.
  - seq_out=PAD, seq_valid=0, busy=0, done=0.
  - full=0, empty=1, level=0.
  - Reset mid-stream aborts the stream; FIFO contents are discarded.
- FIFO:
  - wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
  - count is AW+1 bits.
  - A push is accepted only if count < DEPTH at the start of the cycle. Otherwise it is dropped and overflow is set, even if a pop occurs in the same cycle.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
- States: IDLE, STREAM, DONE (encoded in the package).
- IDLE:
  - seq_valid=0, seq_out=PAD.
  - start=1 with count>0 -> STREAM.
  - start=1 with count==0 -> DONE (empty stream still signals completion).
  - Pushes are accepted in every state.
- STREAM:
  - busy=1.
  - Each cycle with hold=0 and count>0: seq_out<=FIFO[rd_ptr], seq_valid<=1, pop.
  - hold=1: no pop, seq_valid<=0, seq_out keeps its last value.
  - If a pop empties the FIFO (count 1 -> 0 with no accepted push) -> DONE next cycle.
  - Pushes during STREAM are appended and streamed in the same run.
  - start is ignored in STREAM.
- DONE:
  - Lasts one cycle: done=1, seq_valid=0, seq_out=PAD, then -> IDLE.
  - start is ignored in DONE.
- Latency:
  - start sampled at edge t -> STREAM from t+1.
  - First digit on seq_out/seq_valid after edge t+2.
  - N digits with hold=0 occupy N consecutive valid cycles; done is asserted in the cycle after the last valid.
- level, full and empty are combinational from count.

Optional Feature:
- Macro SEQ_FEEDER_CNT_EN.
- Defined:
  - Adds output stream_cnt[7:0], the number of digits emitted (seq_valid cycles) in the current or last stream.
  - Cleared to 0 on reset and on the IDLE->STREAM/DONE transition.
  - Increments per valid digit and saturates at 255.
  - Holds its value through IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package seq_feeder_pkg:
  - DIGIT_W=4.
  - Default PAD=4'hF.
  - State enum (IDLE, STREAM, DONE).
- Sub-module seq_fifo:
  - Circular buffer with pointers, count, full/empty, accept/drop and overflow logic.
  - Exposes push, pop, head data and level.
  - seq_feeder holds the FSM and the output register.

Test Plan:
- Reset, push 1,2,3,4, start, hold=0 -> valid digits 1,2,3,4 on four consecutive cycles starting two cycles after start; done one cycle later; seq_out=F afterwards.
- Push 16 digits, then push 5 -> full=1, level=16, overflow=1, digit 5 never streamed; overflow stays set until reset.
- Stream 1,2,3 with hold=1 for 2 cycles after the first digit -> seq_valid 1,0,0,1,1; sequence 1,2,3 intact; seq_out holds 1 during the stall.
- Start with empty FIFO -> no valid cycles; done pulses the cycle after start; returns to IDLE.
- Stream 7,8 while pushing 9 during STREAM -> output 7,8,9; single done after 9; level 0.
- Assert reset mid-stream after two of four digits -> next cycle seq_valid=0, seq_out=F, level=0, busy=0, no done pulse. With SEQ_FEEDER_CNT_EN, a 300-digit run with continuous refill gives stream_cnt=255.
